// File: rtl/schk_frame_capture.sv
// schk_frame_capture: captures the W payload bits that follow a detected sync word and delivers them on a valid/ack handshake
module schk_frame_capture #(
  parameter int W    = 8,
  parameter int CNTW = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            DIN,
  input  logic            SYNC,
  input  logic            DACK,
  input  logic            CLR_OVR,
  output logic [W-1:0]    DOUT,
  output logic            DVALID,
  output logic            BUSY,
  output logic            OVR,
  output logic [CNTW-1:0] FRM_CNT
);
  localparam int BW = $clog2(W);
  typedef enum logic {IDLE, CAPT} state_t;
  state_t state, state_nxt;
  logic [BW-1:0] cnt, cnt_nxt;
  logic [W-2:0] sh, sh_nxt;
  logic [W-1:0] word;
  logic done, load, drop;
  // sh holds the W-1 earlier payload bits, so the completing bit is appended straight from DIN
  always_comb begin
    word      = {sh, DIN};
    done      = state == CAPT && cnt == BW'(W-1);
    load      = done && (!DVALID || DACK);
    drop      = done && DVALID && !DACK;
    state_nxt = state == IDLE ? (SYNC ? CAPT : IDLE) : (done ? IDLE : CAPT);
    cnt_nxt   = state == IDLE ? BW'(SYNC) : (done ? '0 : cnt + 1'b1);
    sh_nxt    = (state == CAPT || SYNC) ? word[W-2:0] : sh;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= '0;
      sh      <= '0;
      DOUT    <= '0;
      DVALID  <= 1'b0;
      BUSY    <= 1'b0;
      OVR     <= 1'b0;
      FRM_CNT <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      sh     <= sh_nxt;
      BUSY   <= state_nxt == CAPT;
      DVALID <= load | (DVALID & ~DACK);
      OVR    <= drop | (OVR & ~CLR_OVR);
      if (load) begin
        DOUT    <= word;
        FRM_CNT <= FRM_CNT + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_schk_frame_capture.sv
// tb_schk_frame_capture: directed and randomized checks against a queue-based frame model
module tb_schk_frame_capture;
  localparam int W = 8, CNTW = 8;
  logic CLK = 0, RST = 0, DIN = 0, SYNC = 0, DACK = 0, CLR_OVR = 0;
  logic [W-1:0] DOUT;
  logic DVALID, BUSY, OVR;
  logic [CNTW-1:0] FRM_CNT;
  int checks = 0, errors = 0;
  logic [7:0] hist = 0;
  bit m_busy, m_dv, m_ovr;
  bit m_bits[$];
  logic [W-1:0] m_dout;
  logic [CNTW-1:0] m_cnt;

  schk_frame_capture #(.W(W), .CNTW(CNTW)) dut (
    .CLK(CLK), .RST(RST), .DIN(DIN), .SYNC(SYNC), .DACK(DACK), .CLR_OVR(CLR_OVR),
    .DOUT(DOUT), .DVALID(DVALID), .BUSY(BUSY), .OVR(OVR), .FRM_CNT(FRM_CNT));

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".DOUT"}, 32'(DOUT), 32'(m_dout));
    chk({tag, ".DVALID"}, 32'(DVALID), 32'(m_dv));
    chk({tag, ".BUSY"}, 32'(BUSY), 32'(m_busy));
    chk({tag, ".OVR"}, 32'(OVR), 32'(m_ovr));
    chk({tag, ".FRM_CNT"}, 32'(FRM_CNT), 32'(m_cnt));
  endtask

  task automatic model_reset();
    m_busy = 0; m_dv = 0; m_ovr = 0; m_dout = '0; m_cnt = '0;
    m_bits.delete();
    hist = '0;
  endtask

  // SYNC mimics the detector: high in the cycle after the last 8 sent bits were 11101000
  task automatic step(input bit d, input bit ack, input bit clr, input bit force_sync);
    bit s, loaded, dropped;
    logic [W-1:0] w;
    @(negedge CLK);
    DIN = d; DACK = ack; CLR_OVR = clr;
    SYNC = (hist == 8'hE8) || force_sync;
    s = SYNC;
    @(posedge CLK);
    hist = {hist[6:0], d};
    loaded = 0; dropped = 0;
    if (!m_busy) begin
      if (s) begin m_bits.delete(); m_bits.push_back(d); m_busy = 1; end
    end else begin
      m_bits.push_back(d);
      if (m_bits.size() == W) begin
        w = '0;
        foreach (m_bits[i]) w = (w << 1) | W'(m_bits[i]);
        if (!m_dv || ack) begin m_dout = w; m_cnt = m_cnt + 1'b1; loaded = 1; end
        else dropped = 1;
        m_busy = 0;
      end
    end
    m_dv = loaded ? 1'b1 : (m_dv && !ack);
    m_ovr = dropped ? 1'b1 : (m_ovr && !clr);
    #1 chk_all("step");
  endtask

  task automatic send(input logic [7:0] b, input logic [7:0] ack);
    for (int i = 7; i >= 0; i--) step(b[i], ack[i], 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    DIN = 0; DACK = 0; CLR_OVR = 0; SYNC = 0;
    #2 RST = 1;
    model_reset();
    #1 chk_all("reset_async");
    @(negedge CLK);
    RST = 0;
  endtask

  initial begin
    model_reset();
    do_reset();
    chk("reset_dvalid", 32'(DVALID), 32'h0);
    // 1: first frame, no ack
    send(8'hE8, 8'h00);
    send(8'hB3, 8'h00);
    chk("t1_dout", 32'(DOUT), 32'hB3);
    chk("t1_dvalid", 32'(DVALID), 32'h1);
    chk("t1_cnt", 32'(FRM_CNT), 32'h1);
    chk("t1_busy", 32'(BUSY), 32'h0);
    // 2: ack pulse
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("t2_dvalid", 32'(DVALID), 32'h0);
    chk("t2_dout", 32'(DOUT), 32'hB3);
    // 3: overrun, then clear
    do_reset();
    send(8'hE8, 8'h00); send(8'h5A, 8'h00);
    send(8'hE8, 8'h00); send(8'hC3, 8'h00);
    chk("t3_dout", 32'(DOUT), 32'h5A);
    chk("t3_ovr", 32'(OVR), 32'h1);
    chk("t3_cnt", 32'(FRM_CNT), 32'h1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t3_ovr_clr", 32'(OVR), 32'h0);
    // 4: ack coincides with completion
    do_reset();
    send(8'hE8, 8'h00); send(8'h5A, 8'h00);
    send(8'hE8, 8'h00); send(8'hC3, 8'h01);
    chk("t4_dout", 32'(DOUT), 32'hC3);
    chk("t4_dvalid", 32'(DVALID), 32'h1);
    chk("t4_cnt", 32'(FRM_CNT), 32'h2);
    chk("t4_ovr", 32'(OVR), 32'h0);
    // 5: payload that is itself a sync word, plus a SYNC pulse inside CAPT
    do_reset();
    send(8'hE8, 8'h00);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 5; i >= 0; i--) step(1'(8'hE8 >> i), 1'b0, 1'b0, 1'b0);
    chk("t5_dout", 32'(DOUT), 32'hE8);
    chk("t5_cnt", 32'(FRM_CNT), 32'h1);
    chk("t5_busy", 32'(BUSY), 32'h0);
    // 6: reset mid-frame then a clean frame
    do_reset();
    send(8'hE8, 8'h00);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t6_busy_mid", 32'(BUSY), 32'h1);
    do_reset();
    chk("t6_busy_rst", 32'(BUSY), 32'h0);
    send(8'hE8, 8'h00); send(8'h0F, 8'h00);
    chk("t6_dout", 32'(DOUT), 32'h0F);
    chk("t6_cnt", 32'(FRM_CNT), 32'h1);
    // randomized traffic
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(5) == 0) send(8'hE8, 8'($urandom));
      else step(1'($urandom), $urandom_range(2) == 0, $urandom_range(7) == 0, $urandom_range(19) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
